// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_detector
//  Description : Serial bit-pattern detector with a run-time loadable pattern,
//                registered match pulse and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
  parameter int              PAT_W   = 4,
  parameter int              CNT_W   = 8,
  parameter int              OVERLAP = 1,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             data_valid,
  input  logic             data_in,
  input  logic             clr_count,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pattern_q
);

  localparam int               c_FILL_W   = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
  localparam logic [c_FILL_W-1:0] c_FILL_RDY = c_FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX  = {CNT_W{1'b1}};

  // Only the newest PAT_W-1 bits are ever compared, so the oldest is not kept.
  logic [PAT_W-2:0]    r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]    r_pattern;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;

  logic [PAT_W-1:0]    w_cand;
  logic                w_accept;
  logic                w_match;
  logic [c_FILL_W-1:0] w_fill_on_match;

  assign w_cand   = {r_hist, data_in};
  assign w_accept = data_valid & ~cfg_load;
  assign w_match  = w_accept & (r_fill >= c_FILL_RDY) & (w_cand == r_pattern);

  generate
    if (OVERLAP != 0) begin : g_overlap
      assign w_fill_on_match = c_FILL_MAX;
    end else begin : g_restart
      assign w_fill_on_match = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= RST_PAT;
      r_count   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_match;

      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (data_valid) begin
        r_hist <= w_cand[PAT_W-2:0];
        if (w_match) begin
          r_fill <= w_fill_on_match;
        end else if (r_fill != c_FILL_MAX) begin
          r_fill <= r_fill + c_FILL_W'(1);
        end
      end

      // Clear takes priority over a coincident match.
      if (clr_count) begin
        r_count <= '0;
      end else if (w_match && (r_count != c_CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign done        = r_done;
  assign match_count = r_count;
  assign pattern_q   = r_pattern;

endmodule
`default_nettype wire

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector. It compares each accepted input bit against a run-time-loadable pattern of PAT_W bits and emits a registered one-cycle done pulse on every match. Overlapping or non-overlapping matching is selected by parameter, and a saturating match counter is included. It sits on a serial data path after the bit deserialiser and before the control logic that consumes match events.

Parameters:
PAT_W, 4, pattern length in bits (>=2); the first-received bit is compared against the pattern MSB.
CNT_W, 8, width of the match counter.
OVERLAP, 1, 1 = a match's trailing bits may start the next match; 0 = matching restarts after each match.
RST_PAT, 4'b1011, pattern value loaded at reset (PAT_W bits).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
cfg_load  input  1  one-cycle strobe; latch cfg_pattern
cfg_pattern  input  PAT_W  new pattern, sampled when cfg_load=1
data_valid  input  1  data_in qualifier; bits are accepted only when high
data_in  input  1  serial data bit
clr_count  input  1  synchronous clear of match_count
done  output  1  registered match pulse
match_count  output  CNT_W  number of matches since reset/clear, saturating
pattern_q  output  PAT_W  currently active pattern

Behaviour:
- Reset is synchronous and active-low on clk. While rst_n=0, all other inputs are ignored and:
  - done=0, match_count=0, pattern_q=RST_PAT;
  - history register hist=0, fill counter fill=0.
- Internal state:
  - hist[PAT_W-1:0] holds the last accepted bits, with the newest bit at the LSB.
  - fill (0..PAT_W) counts accepted bits since the last restart and saturates at PAT_W.
- Candidate for each cycle: cand = {hist[PAT_W-2:0], data_in}.
- Match condition: cfg_load=0 AND data_valid=1 AND fill>=PAT_W-1 AND cand==pattern_q.
- Accept cycle (data_valid=1, cfg_load=0):
  - hist <= cand.
  - Without a match: fill <= min(fill+1, PAT_W).
  - On a match with OVERLAP=1: fill <= PAT_W.
  - On a match with OVERLAP=0: fill <= 0. hist is still updated, but it is ignored until refilled.
- data_valid=0: hist, fill and pattern_q hold. Gaps in data_valid are transparent, so a pattern may straddle idle cycles.
- done timing:
  - done <= match, registered. It goes high exactly 1 cycle after the cycle that accepted the final pattern bit, for 1 cycle per match.
  - Back-to-back matches produce done high on consecutive cycles.
- cfg_load=1 (priority over data):
  - pattern_q <= cfg_pattern, fill <= 0, hist <= 0.
  - data_in in the same cycle is discarded; done <= 0 next cycle.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
  - It updates in the same edge that sets done, so both reflect the match on the same cycle.
  - clr_count=1 sets it to 0 next edge. If clr_count coincides with a match, clear wins (count=0) but done still pulses.
- Patterns with self-overlap (e.g. 1111, 1010) follow the fill rules above. For example, pattern 1111 with OVERLAP=1 on a continuous run of 1s matches on every bit from the 4th onward.
- Reset mid-stream discards any partial match. The first match after reset needs a full PAT_W accepted bits.

Test Plan:
- Reset, default pattern 1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with data_valid=1 -> done high in the cycle after the 4th and after the 7th bit; match_count=2.
- Same stream with OVERLAP=0 -> single done after the 4th bit; the 7th bit gives no match; match_count=1.
- Pattern 1011 with data_valid low for 3 cycles between bit 2 and bit 3 -> done still pulses once, 1 cycle after the final accepted 1; no pulse during the idle cycles.
- cfg_load with cfg_pattern=0110 after bits 0,1,1 have already been accepted -> no done from those bits; pattern_q=0110; the following bits 0,1,1,0 produce done after the 4th.
- CNT_W=2, OVERLAP=1, pattern 1111, eight consecutive 1s -> done on 5 consecutive cycles; match_count reads 1,2,3,3,3. Then clr_count coinciding with a match -> match_count=0 and done=1.
- Assert rst_n=0 for 1 cycle after bits 1,0,1 -> done=0, match_count=0; a subsequent single bit 1 gives no match; the full sequence 1,0,1,1 gives done.
